// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct
// codes, ALU control codes (also consumed by the ALU) and the FSM state type.
// Optional feature macro: MIPS_MC_ADDI_EN (adds the ADDIEX/ADDIWB states).
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Fixed encodings so the state register can be a plain 4-bit vector and
  // any unused code is recognisable and recoverable.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
`ifdef MIPS_MC_ADDI_EN
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
`else
    S_JUMP    = 4'd9
`endif
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational funct-field decoder producing the ALU control code and a
// flag for unsupported funct values (which fall back to add).
import mips_mc_pkg::*;

module alu_decoder (
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       illegal_funct
);

  // Map each supported R-type funct onto its ALU operation
  always_comb begin
    alu_ctl       = ALU_ADD;
    illegal_funct = 1'b0;
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      default: illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multicycle control unit for the MIPS core. Decodes Op/Funct,
// sequences the datapath and gates all write enables with stall and reset.
// Optional feature macro: MIPS_MC_ADDI_EN (addi support via ADDIEX/ADDIWB).
import mips_mc_pkg::*;

module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [2:0] dec_ctl;
  logic       dec_illegal;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       pc_write;
  logic       branch;
  logic       illegal;
  logic       enable;

  alu_decoder u_alu_decoder (
    .funct         (Funct),
    .alu_ctl       (dec_ctl),
    .illegal_funct (dec_illegal)
  );

  // State register: async reset to FETCH, frozen while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_FETCH;
    else if (!stall)
      state <= next_state;
  end

  // Per-state control decode and next-state selection
  always_comb begin
    next_state = S_FETCH;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUCtl     = ALU_ADD;
    PCSrc      = 2'b00;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        ALUSrcB    = 2'b01;
        pc_write   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      next_state = S_ADDIEX;
`endif
          default:      illegal    = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUCtl  = dec_ctl;
        if (dec_illegal)
          illegal = 1'b1;
        else
          next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUCtl  = ALU_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // Enables and the illegal pulse are suppressed while stalled or in reset;
  // selects stay untouched so the datapath sees steady mux settings.
  assign enable   = !stall && !reset;
  assign IRWrite  = ir_write  & enable;
  assign MemWrite = mem_write & enable;
  assign RegWrite = reg_write & enable;
  assign PCEn     = (pc_write | (branch & Zero)) & enable;
  assign Illegal  = illegal   & enable;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl. Stimulus issues randomized
// instructions (with random stalls and Zero) and queues the expected control
// word for each cycle from a step-level model; a negedge monitor compares.
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUCtl;
  logic       PCEn, Illegal;

  int checksRun = 0;
  int checksPassed = 0;
  logic [15:0] expQ[$];
  logic [15:0] actual;

  localparam int ST_F = 0, ST_D = 1, ST_DILL = 2, ST_MA = 3, ST_MR = 4,
                 ST_MWB = 5, ST_MW = 6, ST_EX = 7, ST_AWB = 8, ST_BR = 9,
                 ST_J = 10, ST_AE = 11, ST_AW = 12;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_J = 4,
                 K_ADDI = 5, K_OTHER = 6;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .Op(Op), .Funct(Funct),
    .Zero(Zero), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl), .PCSrc(PCSrc),
    .PCEn(PCEn), .Illegal(Illegal)
  );

  assign actual = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUCtl, PCSrc, PCEn, Illegal};

  // Free-running clock
  always #5 clk = ~clk;

  // ALU code of a supported funct is its position in this list; -1 if absent
  function automatic int functCode(input logic [5:0] fn);
    logic [5:0] table5 [5];
    table5 = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    functCode = -1;
    for (int i = 0; i < 5; i++)
      if (table5[i] == fn) functCode = i;
  endfunction

  // Reference control word for one cycle of a given instruction step
  function automatic logic [15:0] expectFor(input int step, input logic [5:0] fn,
                                            input logic z, input logic rst,
                                            input logic stl);
    logic iord, mw, irw, rdst, m2r, rw, srca, pcw, br, ill, pcen;
    logic [1:0] srcb, pcsrc;
    logic [2:0] ctl;
    int code;
    {iord, mw, irw, rdst, m2r, rw, srca, pcw, br, ill} = '0;
    srcb = 2'b00; pcsrc = 2'b00; ctl = 3'b000;
    if (rst) step = ST_F;
    case (step)
      ST_F:    begin irw = 1; srcb = 2'b01; pcw = 1; end
      ST_D:    srcb = 2'b11;
      ST_DILL: begin srcb = 2'b11; ill = 1; end
      ST_MA:   begin srca = 1; srcb = 2'b10; end
      ST_MR:   iord = 1;
      ST_MWB:  begin rw = 1; m2r = 1; end
      ST_MW:   begin iord = 1; mw = 1; end
      ST_EX: begin
        srca = 1;
        code = functCode(fn);
        if (code < 0) ill = 1;
        else ctl = 3'(code);
      end
      ST_AWB:  begin rdst = 1; rw = 1; end
      ST_BR:   begin srca = 1; ctl = 3'b001; pcsrc = 2'b01; br = 1; end
      ST_J:    begin pcsrc = 2'b10; pcw = 1; end
      ST_AE:   begin srca = 1; srcb = 2'b10; end
      ST_AW:   rw = 1;
      default: ;
    endcase
    pcen = pcw | (br & z);
    if (rst || stl) begin
      irw = 0; mw = 0; rw = 0; pcen = 0; ill = 0;
    end
    expectFor = {iord, mw, irw, rdst, m2r, rw, srca, srcb, ctl, pcsrc, pcen, ill};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] exp);
    checksRun++;
    if (actual === exp)
      checksPassed++;
    else
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, exp);
  endtask

  // Drive one clock cycle of inputs and queue the expected control word
  task automatic applyStimulus(input logic rst, input logic stl, input int step,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
    @(posedge clk);
    #1;
    reset = rst; stall = stl; Op = op; Funct = fn; Zero = z;
    expQ.push_back(expectFor(step, fn, z, rst, stl));
  endtask

  // One whole instruction; zeroSel < 0 means random Zero, stallIdx < 0 random stalls
  task automatic runInstr(input int kind, input int fnSel, input int zeroSel,
                          input int stallIdx, input int stallLen);
    logic [5:0] op, fn;
    int steps[$];
    int nst;
    logic z;
    fn = 6'($urandom_range(0, 63));
    case (kind)
      K_LW:  begin op = 6'b100011; steps = '{ST_F, ST_D, ST_MA, ST_MR, ST_MWB}; end
      K_SW:  begin op = 6'b101011; steps = '{ST_F, ST_D, ST_MA, ST_MW}; end
      K_R: begin
        op = 6'b000000;
        if (fnSel >= 0) fn = 6'(fnSel);
        else if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
            3: fn = 6'b100101; default: fn = 6'b101010;
          endcase
        end
        if (functCode(fn) >= 0) steps = '{ST_F, ST_D, ST_EX, ST_AWB};
        else steps = '{ST_F, ST_D, ST_EX};
      end
      K_BEQ: begin op = 6'b000100; steps = '{ST_F, ST_D, ST_BR}; end
      K_J:   begin op = 6'b000010; steps = '{ST_F, ST_D, ST_J}; end
      K_ADDI: begin
        op = 6'b001000;
`ifdef MIPS_MC_ADDI_EN
        steps = '{ST_F, ST_D, ST_AE, ST_AW};
`else
        steps = '{ST_F, ST_DILL};
`endif
      end
      default: begin
        do op = 6'($urandom_range(0, 63));
        while (op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd8 ||
               op == 6'd35 || op == 6'd43);
        steps = '{ST_F, ST_DILL};
      end
    endcase
    for (int s = 0; s < steps.size(); s++) begin
      if (stallIdx >= 0) nst = (s == stallIdx) ? stallLen : 0;
      else nst = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      for (int k = 0; k <= nst; k++) begin
        z = (zeroSel >= 0) ? 1'(zeroSel) : 1'($urandom_range(0, 1));
        applyStimulus(1'b0, (k < nst), steps[s], op, fn, z);
      end
    end
  endtask

  // Monitor: every negedge with a queued expectation is one comparison
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput("cycle", expQ.pop_front());
  end

  // Stimulus sequence: reset, directed cases, then random instructions
  initial begin
    applyStimulus(1'b1, 1'b0, ST_F, 6'd0, 6'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, ST_F, 6'd0, 6'd0, 1'b1);

    runInstr(K_LW, -1, -1, -1, 0);
    runInstr(K_R, 6'b101010, -1, -2, 0);
    runInstr(K_R, 6'b100010, -1, -2, 0);
    runInstr(K_BEQ, -1, 1, -2, 0);
    runInstr(K_BEQ, -1, 0, -2, 0);
    runInstr(K_LW, -1, -1, 4, 3);
    runInstr(K_ADDI, -1, -1, -2, 0);
    runInstr(K_R, 6'b111111, -1, -2, 0);

    // sw interrupted by an asynchronous reset in MEMWR
    applyStimulus(1'b0, 1'b0, ST_F,  6'b101011, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, ST_D,  6'b101011, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, ST_MA, 6'b101011, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, ST_MW, 6'b101011, 6'd0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("resetMidMemWr", expectFor(ST_F, 6'd0, Zero, 1'b1, 1'b0));
    applyStimulus(1'b1, 1'b0, ST_F, 6'b101011, 6'd0, 1'b0);
    runInstr(K_J, -1, -1, -2, 0);

    for (int n = 0; n < 300; n++)
      runInstr($urandom_range(K_LW, K_OTHER), -1, -1, -1, 0);

    @(negedge clk);
    @(negedge clk);
    checksRun++;
    if (expQ.size() == 0) checksPassed++;
    else $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
